// File: rtl/sram_wrapper_param.sv
`default_nettype none
// ============================================================================
// Module  : sram_wrapper_param
// Purpose : 1rw1r SRAM array tiled from 32x1024 banks, 2-cycle registered read
// Rev     : 1.0
// ============================================================================
module sram_wrapper_param #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 4096,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   wadr,
  input  logic [DATA_WIDTH-1:0]   d,
  input  logic [DATA_WIDTH/8-1:0] wmask,
  input  logic                    re,
  input  logic [ADDR_WIDTH-1:0]   radr,
  output logic                    rd_ready,
  output logic [DATA_WIDTH-1:0]   q,
  output logic                    rvalid,
  output logic                    err,
  input  logic                    err_clr
);

  localparam int c_ROWS   = DEPTH / 1024;
  localparam int c_COLS   = DATA_WIDTH / 32;
  // One extra MSB keeps the row field non-empty when DEPTH is 1024.
  localparam int c_RSEL_W = ADDR_WIDTH - 9;
  localparam logic [ADDR_WIDTH:0] c_DEPTH = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH:0]   w_wadr_x;
  logic [ADDR_WIDTH:0]   w_radr_x;
  logic [c_RSEL_W-1:0]   w_wrow;
  logic [c_RSEL_W-1:0]   w_rrow;
  logic                  w_wadr_in;
  logic                  w_radr_in;
  logic                  w_wr_ok;
  logic                  w_rd_acc;
  logic                  w_rd_ok;
  logic                  w_oor;
  logic [c_ROWS-1:0][DATA_WIDTH-1:0] w_dout1;
  logic [DATA_WIDTH-1:0] w_row_q;

  logic                  r_rd_pend;
  logic [c_RSEL_W-1:0]   r_rsel;

  assign w_wadr_x  = {1'b0, wadr};
  assign w_radr_x  = {1'b0, radr};
  assign w_wrow    = w_wadr_x[ADDR_WIDTH:10];
  assign w_rrow    = w_radr_x[ADDR_WIDTH:10];
  assign w_wadr_in = (w_wadr_x < c_DEPTH);
  assign w_radr_in = (w_radr_x < c_DEPTH);

  assign rd_ready  = ~(we & re & (wadr == radr));
  assign w_wr_ok   = we & w_wadr_in;
  assign w_rd_acc  = re & rd_ready;
  assign w_rd_ok   = w_rd_acc & w_radr_in;
  assign w_oor     = (we & ~w_wadr_in) | (w_rd_acc & ~w_radr_in);

  for (genvar gr = 0; gr < c_ROWS; gr++) begin : g_row
    logic w_csb0;
    logic w_csb1;
    // Chip selects are active-low and forced off while in reset.
    assign w_csb0 = ~(rst_n & w_wr_ok & (w_wrow == c_RSEL_W'(gr)));
    assign w_csb1 = ~(rst_n & w_rd_ok & (w_rrow == c_RSEL_W'(gr)));

    for (genvar gc = 0; gc < c_COLS; gc++) begin : g_col
      logic [31:0] r_mem [1024];
      logic [31:0] r_dout1;

      // Behaviour of one 32x1024 1rw1r bank: port 0 writes, port 1 reads.
      always_ff @(posedge clk) begin
        if (!w_csb0) begin
          for (int b = 0; b < 4; b++) begin
            if (wmask[gc*4+b]) r_mem[wadr[9:0]][b*8 +: 8] <= d[gc*32+b*8 +: 8];
          end
        end
        if (!w_csb1) r_dout1 <= r_mem[radr[9:0]];
      end

      assign w_dout1[gr][gc*32 +: 32] = r_dout1;
    end
  end

  // Out-of-range rows match no bank, so an out-of-range read returns zero.
  always_comb begin
    w_row_q = '0;
    for (int r = 0; r < c_ROWS; r++) begin
      if (r_rsel == c_RSEL_W'(r)) w_row_q = w_dout1[r];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_pend <= 1'b0;
      r_rsel    <= '0;
      q         <= '0;
      rvalid    <= 1'b0;
      err       <= 1'b0;
    end else begin
      r_rd_pend <= w_rd_acc;
      if (w_rd_acc) r_rsel <= w_rrow;
      rvalid    <= r_rd_pend;
      if (r_rd_pend) q <= w_row_q;
      err       <= w_oor | (err & ~err_clr);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_wrapper_param.sv
`default_nettype none
// ============================================================================
// Module  : tb_sram_wrapper_param
// Purpose : Self-checking bench for sram_wrapper_param with a behavioural model
// Rev     : 1.0
// ============================================================================
module tb_sram_wrapper_param;

  localparam int DW    = 128;
  localparam int DEPTH = 3072;
  localparam int AW    = 12;
  localparam int MW    = DW / 8;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          we      = 1'b0;
  logic          re      = 1'b0;
  logic          err_clr = 1'b0;
  logic [AW-1:0] wadr    = '0;
  logic [AW-1:0] radr    = '0;
  logic [DW-1:0] d       = '0;
  logic [MW-1:0] wmask   = '0;
  logic          rd_ready;
  logic          rvalid;
  logic          err;
  logic [DW-1:0] q;

  int checks = 0;
  int errors = 0;

  sram_wrapper_param #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we),
    .wadr    (wadr),
    .d       (d),
    .wmask   (wmask),
    .re      (re),
    .radr    (radr),
    .rd_ready(rd_ready),
    .q       (q),
    .rvalid  (rvalid),
    .err     (err),
    .err_clr (err_clr)
  );

  always #5 clk = ~clk;

  // Reference model: byte-addressed memory with known-byte tracking and a
  // queue of read results, each due a fixed number of edges after acceptance.
  typedef struct {
    int            due;
    logic [DW-1:0] v;
    logic [MW-1:0] k;
  } rd_t;

  rd_t           pend[$];
  logic [DW-1:0] m_mem   [4096];
  logic [MW-1:0] m_known [4096];
  int            cyc = 0;
  logic          e_rvalid = 1'b0;
  logic          e_err    = 1'b0;
  logic [DW-1:0] e_q      = '0;
  logic [MW-1:0] e_k      = '1;
  logic          acc;
  logic [DW-1:0] got[$];
  int            rv_seen = 0;

  int pool [16] = '{0, 1, 2, 5, 7, 1022, 1023, 1024, 1025, 2047, 2048, 3070, 3071, 3072, 3500, 4095};

  function automatic logic [DW-1:0] bytes2bits(input logic [MW-1:0] m);
    logic [DW-1:0] r;
    for (int i = 0; i < MW; i++) r[i*8 +: 8] = {8{m[i]}};
    return r;
  endfunction

  task automatic model_clear();
    pend.delete();
    e_rvalid = 1'b0;
    e_err    = 1'b0;
    e_q      = '0;
    e_k      = '1;
    for (int i = 0; i < 4096; i++) m_known[i] = '0;
  endtask

  always @(negedge rst_n) model_clear();

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      model_clear();
    end else begin
      e_rvalid = 1'b0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        e_q      = pend[0].v;
        e_k      = pend[0].k;
        e_rvalid = 1'b1;
        void'(pend.pop_front());
      end
      acc = re && !(we && wadr == radr);
      if (acc) begin
        if (radr < DEPTH) pend.push_back('{cyc + 1, m_mem[radr], m_known[radr]});
        else              pend.push_back('{cyc + 1, '0, '1});
      end
      e_err = (we && wadr >= DEPTH) || (acc && radr >= DEPTH) || (e_err && !err_clr);
      if (we && wadr < DEPTH) begin
        for (int i = 0; i < MW; i++) begin
          if (wmask[i]) begin
            m_mem[wadr][i*8 +: 8] = d[i*8 +: 8];
            m_known[wadr][i]      = 1'b1;
          end
        end
      end
    end
  end

  task automatic chk1(input string n, input logic g, input logic e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s: got %b expected %b at t=%0t", n, g, e, $time);
    end
  endtask

  task automatic chkv(input string n, input logic [DW-1:0] g, input logic [DW-1:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, g, e);
    end
  endtask

  always @(negedge clk) begin
    chk1("rvalid", rvalid, e_rvalid);
    chk1("err", err, e_err);
    chk1("rd_ready", rd_ready, !(we && re && wadr == radr));
    checks++;
    if (((q ^ e_q) & bytes2bits(e_k)) != '0) begin
      errors++;
      $display("FAIL q: got %h expected %h (known bytes %h) at t=%0t", q, e_q, e_k, $time);
    end
    if (rvalid) begin
      got.push_back(q);
      rv_seen++;
    end
  end

  task automatic op(input logic w, input int wa, input logic [DW-1:0] dd, input logic [MW-1:0] m,
                    input logic r, input int ra, input logic c = 1'b0);
    we = w; wadr = AW'(wa); d = dd; wmask = m;
    re = r; radr = AW'(ra); err_clr = c;
    @(posedge clk);
    #1;
    we = 1'b0; re = 1'b0; err_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_data(input string n, input logic [DW-1:0] e);
    logic [DW-1:0] g;
    checks++;
    if (got.size() == 0) begin
      errors++;
      $display("FAIL %s: no read data returned, expected %h", n, e);
    end else begin
      g = got.pop_front();
      if (g !== e) begin
        errors++;
        $display("FAIL %s: got %h expected %h", n, g, e);
      end
    end
  endtask

  initial begin
    int rv_before;
    repeat (3) @(posedge clk);
    #1;
    chkv("reset_q", q, '0);
    chk1("reset_rvalid", rvalid, 1'b0);
    chk1("reset_err", err, 1'b0);
    rst_n = 1'b1;

    op(1, 0, {16{8'hA5}}, '1, 0, 0);
    op(0, 0, '0, '0, 1, 0);
    idle(3);
    expect_data("a5_read", {16{8'hA5}});

    op(1, 1023, {8{16'h1111}}, '1, 0, 0);
    op(1, 1024, {8{16'h2222}}, '1, 0, 0);
    op(0, 0, '0, '0, 1, 1023);
    op(0, 0, '0, '0, 1, 1024);
    idle(3);
    expect_data("row_edge_1023", {8{16'h1111}});
    expect_data("row_edge_1024", {8{16'h2222}});

    op(1, 5, '1, '1, 0, 0);
    op(1, 5, '0, 16'h000F, 0, 0);
    op(0, 0, '0, '0, 1, 5);
    idle(3);
    expect_data("masked_write", {{12{8'hFF}}, {4{8'h00}}});

    we = 1'b1; wadr = 7; d = {8{16'hDEAD}}; wmask = '1; re = 1'b1; radr = 7;
    #1;
    chk1("collision_rd_ready", rd_ready, 1'b0);
    @(posedge clk);
    #1;
    we = 1'b0; re = 1'b0;
    op(0, 0, '0, '0, 1, 7);
    idle(3);
    expect_data("collision_retry", {8{16'hDEAD}});

    op(1, 428,  {16{8'h01}}, '1, 0, 0);
    op(1, 1452, {16{8'h02}}, '1, 0, 0);
    op(1, 2476, {16{8'h03}}, '1, 0, 0);
    op(1, 3500, {16{8'h5A}}, '1, 0, 0);
    chk1("oor_write_err", err, 1'b1);
    op(0, 0, '0, '0, 1, 3500);
    op(0, 0, '0, '0, 1, 428);
    op(0, 0, '0, '0, 1, 1452);
    op(0, 0, '0, '0, 1, 2476);
    idle(3);
    expect_data("oor_read_zero", '0);
    expect_data("alias_row0", {16{8'h01}});
    expect_data("alias_row1", {16{8'h02}});
    expect_data("alias_row2", {16{8'h03}});
    op(0, 0, '0, '0, 0, 0, 1'b1);
    chk1("err_cleared", err, 1'b0);
    op(1, 3600, '1, '1, 0, 0, 1'b1);
    chk1("err_clr_vs_set", err, 1'b1);
    op(0, 0, '0, '0, 0, 0, 1'b1);
    chk1("err_cleared_again", err, 1'b0);

    got.delete();
    op(0, 0, '0, '0, 1, 0);
    op(0, 0, '0, '0, 1, 1024);
    #2;
    rst_n = 1'b0;
    rv_before = rv_seen;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(4);
    checks++;
    if (rv_seen != rv_before) begin
      errors++;
      $display("FAIL reset_cancel: got %0d rvalid pulses expected 0", rv_seen - rv_before);
    end
    chkv("reset_cancel_q", q, '0);

    foreach (pool[i]) begin
      if (pool[i] < DEPTH) op(1, pool[i], {$urandom(), $urandom(), $urandom(), $urandom()}, '1, 0, 0);
    end
    repeat (1500) begin
      op(1'($urandom_range(0, 1)), pool[$urandom_range(0, 15)],
         {$urandom(), $urandom(), $urandom(), $urandom()}, MW'($urandom()),
         1'($urandom_range(0, 1)), pool[$urandom_range(0, 15)],
         1'($urandom_range(0, 15) == 0));
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
